// File: rtl/calc_core.sv
// rtl/calc_core.sv - four-function BCD calculator engine: digit entry, binary arithmetic, BCD display
module calc_core #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          num_val,
    input  logic [1:0]          op_val,
    input  logic                is_num,
    input  logic                is_op,
    input  logic                is_eq,
    output logic [4*DIGITS-1:0] data_out_bcd,
    output logic                busy,
    output logic                err
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int NW = $clog2(DIGITS + 1);
    localparam logic [2*WIDTH-1:0] MAXV = (2*WIDTH)'(10**DIGITS - 1);

    localparam logic [2:0] S_A   = 3'd0;
    localparam logic [2:0] S_B   = 3'd1;
    localparam logic [2:0] S_RES = 3'd2;
    localparam logic [2:0] S_ERR = 3'd3;
    localparam logic [2:0] CVT_A = 3'd4;
    localparam logic [2:0] CVT_B = 3'd5;
    localparam logic [2:0] EXEC  = 3'd6;
    localparam logic [2:0] CONV  = 3'd7;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    logic [2:0]         r_state;
    logic               r_num_q, r_op_q, r_eq_q;
    logic               r_ev_num, r_ev_op, r_ev_eq;
    logic [3:0]         r_ev_digit;
    logic [1:0]         r_ev_opv;
    logic [BW-1:0]      r_disp;
    logic [NW-1:0]      r_ndig;
    logic [1:0]         r_op, r_next_op;
    logic               r_chain;
    logic [BW-1:0]      r_cvt;
    logic [WIDTH-1:0]   r_acc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a, r_b, r_res, r_bin, r_rem, r_quo;
    logic [2*WIDTH-1:0] r_mc, r_prod;
    logic [BW-1:0]      r_bcd;
    logic               r_err;

    logic               w_num_edge, w_op_edge, w_eq_edge;
    logic [BW-1:0]      w_first, w_digit_in, w_bcd_nxt;
    logic               w_room, w_last_cvt, w_last;
    logic [WIDTH-1:0]   w_acc_nxt, w_diff, w_quo_nxt, w_rem_nxt, w_res;
    logic [WIDTH:0]     w_sum, w_rem_sh, w_trial;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic               w_done, w_fail;

    assign w_num_edge = is_num & ~r_num_q;
    assign w_op_edge  = is_op & ~r_op_q;
    assign w_eq_edge  = is_eq & ~r_eq_q;

    assign w_first    = {{(BW-4){1'b0}}, r_ev_digit};
    assign w_digit_in = (r_ndig == '0) ? w_first : {r_disp[BW-5:0], r_ev_digit};
    assign w_room     = (r_ndig < NW'(DIGITS));
    assign w_last_cvt = (r_cnt == CW'(DIGITS - 1));
    assign w_last     = (r_cnt == CW'(WIDTH - 1));

    assign w_acc_nxt  = r_acc * WIDTH'(10) + WIDTH'(r_cvt[BW-1 -: 4]);
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff     = r_a - r_b;
    assign w_prod_nxt = r_prod + (r_b[0] ? r_mc : '0);

    // Restoring division step: remainder never exceeds the divisor, so WIDTH bits hold it.
    assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_b};
    assign w_rem_nxt  = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_quo_nxt  = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    // Double dabble: add-3-then-shift is folded into shift-then-add-6 per nibble.
    always_comb begin
        w_bcd_nxt = {r_bcd[BW-2:0], r_bin[WIDTH-1]};
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_nxt = w_bcd_nxt + (BW'(6) << (4*i));
        end
    end

    always_comb begin
        w_done = 1'b0;
        w_fail = 1'b0;
        w_res  = '0;
        case (r_op)
            OP_ADD: begin w_done = 1'b1; w_fail = (w_sum > MAXV[WIDTH:0]); w_res = w_sum[WIDTH-1:0]; end
            OP_SUB: begin w_done = 1'b1; w_fail = (r_a < r_b); w_res = w_diff; end
            OP_MUL: begin w_done = w_last; w_fail = w_last && (w_prod_nxt > MAXV); w_res = w_prod_nxt[WIDTH-1:0]; end
            default: begin w_done = w_last; w_fail = (r_b == '0); w_res = w_quo_nxt; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_A;
            r_num_q <= 1'b0; r_op_q <= 1'b0; r_eq_q <= 1'b0;
            r_ev_num <= 1'b0; r_ev_op <= 1'b0; r_ev_eq <= 1'b0;
            r_ev_digit <= '0; r_ev_opv <= '0;
            r_disp <= '0; r_ndig <= '0; r_op <= '0; r_next_op <= '0; r_chain <= 1'b0;
            r_cvt <= '0; r_acc <= '0; r_cnt <= '0;
            r_a <= '0; r_b <= '0; r_res <= '0; r_bin <= '0; r_rem <= '0; r_quo <= '0;
            r_mc <= '0; r_prod <= '0; r_bcd <= '0; r_err <= 1'b0;
        end else begin
            r_num_q    <= is_num;
            r_op_q     <= is_op;
            r_eq_q     <= is_eq;
            r_ev_eq    <= w_eq_edge;
            r_ev_op    <= w_op_edge & ~w_eq_edge;
            r_ev_num   <= w_num_edge & ~w_eq_edge & ~w_op_edge & (num_val <= 4'd9);
            r_ev_digit <= num_val;
            r_ev_opv   <= op_val;

            case (r_state)
                S_A: begin
                    if (r_ev_op) begin
                        r_op <= r_ev_opv; r_cvt <= r_disp; r_acc <= '0; r_cnt <= '0; r_state <= CVT_A;
                    end else if (r_ev_num && w_room) begin
                        r_disp <= w_digit_in; r_ndig <= r_ndig + 1'b1;
                    end
                end
                S_B: begin
                    if (r_ev_eq) begin
                        if (r_ndig != '0) begin
                            r_chain <= 1'b0; r_cvt <= r_disp; r_acc <= '0; r_cnt <= '0; r_state <= CVT_B;
                        end
                    end else if (r_ev_op) begin
                        if (r_ndig == '0) begin
                            r_op <= r_ev_opv;
                        end else begin
                            r_chain <= 1'b1; r_next_op <= r_ev_opv;
                            r_cvt <= r_disp; r_acc <= '0; r_cnt <= '0; r_state <= CVT_B;
                        end
                    end else if (r_ev_num && w_room) begin
                        r_disp <= w_digit_in; r_ndig <= r_ndig + 1'b1;
                    end
                end
                CVT_A, CVT_B: begin
                    r_acc <= w_acc_nxt;
                    r_cvt <= r_cvt << 4;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last_cvt) begin
                        r_cnt <= '0;
                        if (r_state == CVT_A) begin
                            r_a <= w_acc_nxt; r_ndig <= '0; r_state <= S_B;
                        end else begin
                            r_b <= w_acc_nxt; r_mc <= {{WIDTH{1'b0}}, r_a}; r_prod <= '0;
                            r_rem <= '0; r_quo <= r_a; r_state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op == OP_MUL) begin
                        r_prod <= w_prod_nxt; r_mc <= r_mc << 1; r_b <= r_b >> 1;
                    end else if (r_op != OP_ADD && r_op != OP_SUB) begin
                        r_rem <= w_rem_nxt; r_quo <= w_quo_nxt;
                    end
                    if (w_fail) begin
                        r_disp <= {DIGITS{4'hE}}; r_err <= 1'b1; r_state <= S_ERR;
                    end else if (w_done) begin
                        r_res <= w_res; r_bin <= w_res; r_bcd <= '0; r_cnt <= '0; r_state <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= w_bcd_nxt;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_disp <= w_bcd_nxt;
                        r_cnt  <= '0;
                        if (r_chain) begin
                            r_a <= r_res; r_op <= r_next_op; r_ndig <= '0; r_state <= S_B;
                        end else begin
                            r_state <= S_RES;
                        end
                    end
                end
                S_RES: begin
                    if (r_ev_num) begin
                        r_disp <= w_first; r_ndig <= NW'(1); r_state <= S_A;
                    end else if (r_ev_op) begin
                        r_a <= r_res; r_op <= r_ev_opv; r_ndig <= '0; r_state <= S_B;
                    end
                end
                default: begin
                    if (r_ev_num) begin
                        r_disp <= w_first; r_ndig <= NW'(1); r_err <= 1'b0; r_state <= S_A;
                    end
                end
            endcase
        end
    end

    assign data_out_bcd = r_disp;
    assign busy         = (r_state == CVT_A) || (r_state == CVT_B) || (r_state == EXEC) || (r_state == CONV);
    assign err          = r_err;

endmodule

// File: tb/tb_calc_core.sv
// tb/tb_calc_core.sv - directed self-checking bench for calc_core
module tb_calc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  num_val = '0;
    logic [1:0]  op_val = '0;
    logic        is_num = 1'b0, is_op = 1'b0, is_eq = 1'b0;
    logic [15:0] data_out_bcd;
    logic        busy, err;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, DIV = 2'b11;

    always #5 clk = ~clk;

    calc_core dut (
        .clk(clk), .rst(rst), .num_val(num_val), .op_val(op_val),
        .is_num(is_num), .is_op(is_op), .is_eq(is_eq),
        .data_out_bcd(data_out_bcd), .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset;
        rst = 1'b0; is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input logic n, input logic o, input logic e, input logic [3:0] v);
        @(negedge clk);
        num_val = v; op_val = v[1:0];
        is_num = n; is_op = o; is_eq = e;
        @(negedge clk);
        is_num = 1'b0; is_op = 1'b0; is_eq = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", (n < budget), 1);
    endtask

    task automatic k_num(input logic [3:0] d);
        press(1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic k_op(input logic [1:0] o);
        press(1'b0, 1'b1, 1'b0, {2'b00, o});
        wait_idle(40);
    endtask

    task automatic k_eq;
        press(1'b0, 1'b0, 1'b1, 4'd0);
        wait_idle(80);
    endtask

    task automatic eq_latency(output int lat);
        logic [15:0] old;
        @(negedge clk);
        is_eq = 1'b1;
        old = data_out_bcd;
        @(posedge clk); #1;
        is_eq = 1'b0;
        lat = 0;
        while (data_out_bcd === old && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   nb;
        int   lat;
        logic busy_seen;

        repeat (2) @(negedge clk);
        chk("rst_disp", data_out_bcd, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        @(negedge clk);

        busy_seen = 1'b0;
        for (int d = 1; d <= 5; d++) begin
            k_num(4'(d));
            busy_seen = busy_seen | busy;
            if (d == 4) chk("entry_4digits", data_out_bcd, 16'h1234);
        end
        chk("entry_5th_ignored", data_out_bcd, 16'h1234);
        chk("entry_busy_low", busy_seen, 0);

        do_reset;
        k_num(4'd3);
        k_num(4'd12);
        chk("digit_gt9_ignored", data_out_bcd, 16'h0003);

        do_reset;
        k_num(4'd1); k_num(4'd2); k_op(ADD);
        chk("a_kept_after_op", data_out_bcd, 16'h0012);
        k_num(4'd3);
        chk("b_first_digit_clears", data_out_bcd, 16'h0003);
        k_num(4'd4);
        @(negedge clk);
        is_eq = 1'b1;
        @(posedge clk); #1;
        is_eq = 1'b0;
        chk("add_busy_at_edge", busy, 0);
        nb = 0;
        for (int i = 1; i <= 19; i++) begin
            @(posedge clk); #1;
            if (busy) nb++;
        end
        chk("add_busy_cycles", nb, 19);
        chk("add_disp_before_update", data_out_bcd, 16'h0034);
        @(posedge clk); #1;
        chk("add_result_at_20", data_out_bcd, 16'h0046);
        chk("add_busy_released", busy, 0);
        press(1'b0, 1'b0, 1'b1, 4'd0);
        chk("sres_eq_ignored_busy", busy, 0);
        chk("sres_eq_ignored_disp", data_out_bcd, 16'h0046);

        do_reset;
        k_num(4'd9); k_num(4'd9); k_op(MUL);
        k_num(4'd1); k_num(4'd0); k_num(4'd1);
        eq_latency(lat);
        chk("mul_latency_33", lat, 33);
        chk("mul_99x101", data_out_bcd, 16'h9999);
        chk("mul_no_err", err, 0);

        do_reset;
        k_num(4'd1); k_num(4'd0); k_num(4'd0); k_op(MUL);
        k_num(4'd1); k_num(4'd0); k_num(4'd0); k_eq;
        chk("mul_ovf_err", err, 1);
        chk("mul_ovf_disp", data_out_bcd, 16'hEEEE);
        press(1'b0, 1'b1, 1'b0, 4'd0);
        chk("err_op_ignored", data_out_bcd, 16'hEEEE);
        chk("err_op_no_busy", busy, 0);
        k_num(4'd7);
        chk("err_exit_disp", data_out_bcd, 16'h0007);
        chk("err_exit_clear", err, 0);

        do_reset;
        k_num(4'd5); k_op(SUB); k_num(4'd9); k_eq;
        chk("sub_neg_err", err, 1);
        chk("sub_neg_disp", data_out_bcd, 16'hEEEE);

        do_reset;
        k_num(4'd7); k_op(DIV); k_num(4'd0); k_eq;
        chk("div0_err", err, 1);
        chk("div0_disp", data_out_bcd, 16'hEEEE);

        do_reset;
        k_num(4'd1); k_num(4'd0); k_num(4'd0); k_op(DIV); k_num(4'd7);
        eq_latency(lat);
        chk("div_latency_33", lat, 33);
        chk("div_100_7", data_out_bcd, 16'h0014);
        k_op(ADD); k_num(4'd6); k_eq;
        chk("sres_op_continue", data_out_bcd, 16'h0020);

        do_reset;
        k_num(4'd2); k_op(ADD); k_num(4'd3); k_op(MUL);
        chk("chain_partial", data_out_bcd, 16'h0005);
        k_num(4'd4); k_eq;
        chk("chain_result", data_out_bcd, 16'h0020);

        do_reset;
        k_num(4'd6); k_op(ADD);
        press(1'b0, 1'b0, 1'b1, 4'd0);
        chk("sb_eq_ignored_busy", busy, 0);
        chk("sb_eq_ignored_disp", data_out_bcd, 16'h0006);
        k_op(SUB); k_num(4'd2); k_eq;
        chk("op_replaced", data_out_bcd, 16'h0004);

        do_reset;
        k_num(4'd8);
        press(1'b1, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        num_val = 4'd5;
        wait_idle(40);
        chk("op_beats_num_disp", data_out_bcd, 16'h0008);
        k_num(4'd2); k_eq;
        chk("op_beats_num_result", data_out_bcd, 16'h0010);

        do_reset;
        k_num(4'd9); k_num(4'd9); k_op(MUL); k_num(4'd9); k_num(4'd9);
        press(1'b0, 1'b0, 1'b1, 4'd0);
        repeat (8) @(posedge clk);
        #2;
        chk("mid_exec_busy", busy, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_disp", data_out_bcd, 16'h0000);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_err", err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        k_num(4'd1);
        chk("post_rst_digit", data_out_bcd, 16'h0001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
